// File: rtl/sr_readback_rx.sv
// -----------------------------------------------------------------------------
// sr_readback_rx
//
// Reads a WIDTH-bit frame back out of an external serial shift register.
// The block generates the shift clock (clk_sr) itself. It sees the shift
// register's last stage on sr_dout and assembles the bits into a parallel word.
// The first bit received ends up at the MSB of data_out.
//
// Frame sequence: IDLE -> (SHIFT_LO -> SHIFT_HI) x WIDTH -> DONE -> IDLE.
// Every output is a register. Each one is loaded with the value that belongs
// to the state being entered, so it changes on the same edge as the state.
//
// Optional feature (macro SR_READBACK_CMP_EN):
//   Adds the input expected[WIDTH-1:0] and the output mismatch. mismatch is
//   loaded in DONE, together with data_valid. It is high when any captured bit
//   differs from expected.
//
// Ports:
//   clk        in   module clock, rising edge
//   rst        in   asynchronous reset, active low
//   start      in   request one readback frame (ignored while busy)
//   sr_dout    in   serial data from the shift register's last stage
//   clk_sr     out  registered shift clock; idles high
//   busy       out  a frame is in progress
//   data_out   out  last captured frame, first bit received at MSB
//   data_valid out  one-cycle pulse when data_out updates
//   count      out  bits captured in the current frame (saturates at WIDTH)
//   expected   in   (SR_READBACK_CMP_EN only) reference frame
//   mismatch   out  (SR_READBACK_CMP_EN only) captured frame != expected
// -----------------------------------------------------------------------------
module sr_readback_rx #(
    parameter int WIDTH     = 170,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sr_dout,
`ifdef SR_READBACK_CMP_EN
    input  logic [WIDTH-1:0]     expected,
    output logic                 mismatch,
`endif
    output logic                 clk_sr,
    output logic                 busy,
    output logic [WIDTH-1:0]     data_out,
    output logic                 data_valid,
    output logic [CNT_WIDTH-1:0] count
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(WIDTH);

    state_t                r_state;
    logic                  r_clk_sr;
    logic                  r_busy;
    logic                  r_data_valid;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [WIDTH-1:0]      r_capture;
    logic [WIDTH-1:0]      r_data_out;

    state_t                w_state_nxt;
    logic                  w_clk_sr_nxt;
    logic                  w_busy_nxt;
    logic                  w_data_valid_nxt;
    logic [CNT_WIDTH-1:0]  w_count_nxt;
    logic [WIDTH-1:0]      w_capture_nxt;
    logic [WIDTH-1:0]      w_data_out_nxt;

`ifdef SR_READBACK_CMP_EN
    logic                  r_mismatch;
    logic                  w_mismatch_nxt;
`endif

    // Next state and next values of the registered outputs.
    // NOTE: every signal gets a default before the case statement. Without a
    // default, a branch that skips an assignment would infer a latch.
    always_comb begin
        w_state_nxt      = r_state;
        w_clk_sr_nxt     = r_clk_sr;
        w_busy_nxt       = r_busy;
        w_data_valid_nxt = 1'b0;
        w_count_nxt      = r_count;
        w_capture_nxt    = r_capture;
        w_data_out_nxt   = r_data_out;
`ifdef SR_READBACK_CMP_EN
        w_mismatch_nxt   = r_mismatch;
`endif

        case (r_state)
            IDLE: begin
                w_clk_sr_nxt = 1'b1;
                w_busy_nxt   = 1'b0;
                if (start) begin
                    w_state_nxt  = SHIFT_LO;
                    w_clk_sr_nxt = 1'b0;
                    w_busy_nxt   = 1'b1;
                    w_count_nxt  = '0;
                end
            end

            // The shift register advances on this falling edge of clk_sr.
            // sr_dout then has a full cycle to settle before it is sampled.
            SHIFT_LO: begin
                w_state_nxt  = SHIFT_HI;
                w_clk_sr_nxt = 1'b1;
            end

            SHIFT_HI: begin
                // A shift instead of a slice, so that WIDTH=1 also works.
                w_capture_nxt = (r_capture << 1) | WIDTH'(sr_dout);
                if (r_count != CNT_MAX) begin
                    w_count_nxt = r_count + 1'b1;
                end
                if (r_count == CNT_LAST) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt  = SHIFT_LO;
                    w_clk_sr_nxt = 1'b0;
                end
            end

            // start is not looked at here, so a request in DONE is dropped.
            DONE: begin
                w_state_nxt      = IDLE;
                w_data_out_nxt   = r_capture;
                w_data_valid_nxt = 1'b1;
                w_busy_nxt       = 1'b0;
`ifdef SR_READBACK_CMP_EN
                w_mismatch_nxt   = |(r_capture ^ expected);
`endif
            end

            default: begin
                w_state_nxt  = IDLE;
                w_clk_sr_nxt = 1'b1;
                w_busy_nxt   = 1'b0;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments. All registers then
    // see values from before the edge, whatever order the blocks run in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_clk_sr     <= 1'b1;
            r_busy       <= 1'b0;
            r_data_valid <= 1'b0;
            r_count      <= '0;
            r_capture    <= '0;
            r_data_out   <= '0;
`ifdef SR_READBACK_CMP_EN
            r_mismatch   <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_clk_sr     <= w_clk_sr_nxt;
            r_busy       <= w_busy_nxt;
            r_data_valid <= w_data_valid_nxt;
            r_count      <= w_count_nxt;
            r_capture    <= w_capture_nxt;
            r_data_out   <= w_data_out_nxt;
`ifdef SR_READBACK_CMP_EN
            r_mismatch   <= w_mismatch_nxt;
`endif
        end
    end

    assign clk_sr     = r_clk_sr;
    assign busy       = r_busy;
    assign data_valid = r_data_valid;
    assign count      = r_count;
    assign data_out   = r_data_out;
`ifdef SR_READBACK_CMP_EN
    assign mismatch   = r_mismatch;
`endif

endmodule

// File: tb/tb_sr_readback_rx.sv
// -----------------------------------------------------------------------------
// tb_sr_readback_rx
//
// Directed bench for sr_readback_rx with WIDTH=170.
//
// A behavioural shift register drives sr_dout. On every falling edge of clk_sr
// it presents the next bit of the loaded pattern, MSB first. Each scenario is
// its own task. Outputs are sampled 1 time unit after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_sr_readback_rx;

    localparam int W  = 170;
    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic          sr_dout;
    logic          clk_sr;
    logic          busy;
    logic [W-1:0]  data_out;
    logic          data_valid;
    logic [CW-1:0] count;
`ifdef SR_READBACK_CMP_EN
    logic [W-1:0]  expected;
    logic          mismatch;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Serial model state.
    logic [W-1:0] pat;
    int           idx;
    int           lo_pulses;

    sr_readback_rx #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sr_dout    (sr_dout),
`ifdef SR_READBACK_CMP_EN
        .expected   (expected),
        .mismatch   (mismatch),
`endif
        .clk_sr     (clk_sr),
        .busy       (busy),
        .data_out   (data_out),
        .data_valid (data_valid),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External shift register: each falling edge of clk_sr presents the next bit.
    always @(negedge clk_sr) begin
        sr_dout = (idx < W) ? pat[W-1-idx] : 1'b0;
        idx++;
        lo_pulses++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
        $fatal(1);
    end

    task automatic load(input logic [W-1:0] p);
        pat       = p;
        idx       = 0;
        lo_pulses = 0;
    endtask

    // Counts rising edges (from the current one) until data_valid is seen.
    // Returns -1 if data_valid does not appear within 400 edges.
    task automatic run_to_valid(inout int n);
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            n++;
            if (data_valid === 1'b1) return;
        end
        n = -1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset;
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (clk_sr !== 1'b1 || busy !== 1'b0 || data_valid !== 1'b0 ||
            count !== '0 || data_out !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: clk_sr=%b busy=%b dv=%b count=%0d data_out=%h, want 1 0 0 0 0",
                     clk_sr, busy, data_valid, count, data_out);
        end
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (clk_sr !== 1'b1 || busy !== 1'b0 || data_valid !== 1'b0 ||
                count !== '0 || data_out !== '0) begin
                miscompares++;
                $display("FAIL idle_cycle_%0d: clk_sr=%b busy=%b dv=%b count=%0d data_out=%h, want 1 0 0 0 0",
                         c, clk_sr, busy, data_valid, count, data_out);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_single_frame;
        logic [W-1:0] p;
        logic [W-1:0] held;
        int n;
        p = {85{2'b10}};   // MSB=1, LSB=0, alternating in between
        load(p);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if (clk_sr !== 1'b0 || busy !== 1'b1 || count !== '0) begin
            miscompares++;
            $display("FAIL frame_launch: clk_sr=%b busy=%b count=%0d, want 0 1 0", clk_sr, busy, count);
        end
        n = 0;
        run_to_valid(n);
        vectors++;
        if (n !== 341) begin
            miscompares++;
            $display("FAIL frame_latency: got %0d edges, want 341", n);
        end
        vectors++;
        if (data_out !== p) begin
            miscompares++;
            $display("FAIL frame_data: got %h want %h", data_out, p);
        end
        vectors++;
        if (lo_pulses !== 170) begin
            miscompares++;
            $display("FAIL frame_lo_pulses: got %0d want 170", lo_pulses);
        end
        vectors++;
        if (count !== CW'(170) || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_end_state: count=%0d busy=%b, want 170 0", count, busy);
        end
        held = data_out;
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (data_valid !== 1'b0 || data_out !== held || count !== CW'(170) || clk_sr !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_hold: dv=%b count=%0d clk_sr=%b data_out=%h, want 0 170 1 %h",
                     data_valid, count, clk_sr, data_out, held);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_busy_ignore;
        logic [W-1:0] p1;
        logic [W-1:0] p2;
        int n;
        int valids;
        p1 = {W{1'b0}};
        p1[W-1] = 1'b1;
        p1[3:0] = 4'b1011;
        p2 = ~p1;
        load(p1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        valids = 0;
        for (int k = 0; k < 400 && valids == 0; k++) begin
            @(posedge clk); #1;
            n++;
            start = (n == 100) || (n == 340);   // at bit 50, and while in DONE
            if (data_valid === 1'b1) valids++;
        end
        start = 1'b0;
        vectors++;
        if (n !== 341 || data_out !== p1) begin
            miscompares++;
            $display("FAIL busy_frame: edges=%0d data=%h, want 341 %h", n, data_out, p1);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (data_valid === 1'b1 || busy === 1'b1 || clk_sr !== 1'b1) valids++;
        end
        vectors++;
        if (valids !== 1) begin
            miscompares++;
            $display("FAIL busy_no_extra_frame: activity count %0d, want 1", valids);
        end
        load(p2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        run_to_valid(n);
        vectors++;
        if (n !== 341 || data_out !== p2) begin
            miscompares++;
            $display("FAIL busy_second_frame: edges=%0d data=%h, want 341 %h", n, data_out, p2);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid_frame;
        logic [W-1:0] p;
        int n;
        int bad;
        p = {W{1'b1}};
        p[W-1] = 1'b0;
        p[0]   = 1'b1;
        p[85]  = 1'b0;
        load(p);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        vectors++;
        if (count !== CW'(100) || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_pre: count=%0d busy=%b, want 100 1", count, busy);
        end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (clk_sr !== 1'b1 || busy !== 1'b0 || count !== '0 ||
            data_valid !== 1'b0 || data_out !== '0) begin
            miscompares++;
            $display("FAIL midreset_async: clk_sr=%b busy=%b count=%0d dv=%b data_out=%h, want 1 0 0 0 0",
                     clk_sr, busy, count, data_valid, data_out);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (data_valid !== 1'b0 || busy !== 1'b0 || clk_sr !== 1'b1) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL midreset_no_restart: %0d active cycles, want 0", bad);
        end
        load(p);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        run_to_valid(n);
        vectors++;
        if (n !== 341 || data_out !== p || lo_pulses !== 170) begin
            miscompares++;
            $display("FAIL midreset_new_frame: edges=%0d pulses=%0d data=%h, want 341 170 %h",
                     n, lo_pulses, data_out, p);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_back_to_back;
        logic [W-1:0] pats [3];
        logic [175:0] a5;
        int n;
        a5 = {22{8'hA5}};
        pats[0] = {W{1'b1}};
        pats[1] = {W{1'b0}};
        pats[2] = a5[W-1:0];
        load(pats[0]);
        start = 1'b1;
        @(posedge clk); #1;
        for (int f = 0; f < 3; f++) begin
            n = 0;
            run_to_valid(n);
            if (f == 2) start = 1'b0;
            vectors++;
            if (n !== ((f == 0) ? 341 : 342)) begin
                miscompares++;
                $display("FAIL b2b_spacing_%0d: got %0d edges, want %0d", f, n, (f == 0) ? 341 : 342);
            end
            vectors++;
            if (data_out !== pats[f] || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_data_%0d: data=%h busy=%b, want %h 0", f, data_out, busy, pats[f]);
            end
            if (f < 2) load(pats[f+1]);
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || clk_sr !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_stop: busy=%b clk_sr=%b, want 0 1", busy, clk_sr);
        end
    endtask

`ifdef SR_READBACK_CMP_EN
    // ------------------------------------------------------------------------
    task automatic test_compare;
        logic [W-1:0] p;
        int n;
        p = {85{2'b01}};
        expected = p;
        load(p);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        run_to_valid(n);
        vectors++;
        if (mismatch !== 1'b0 || n !== 341) begin
            miscompares++;
            $display("FAIL cmp_match: mismatch=%b edges=%0d, want 0 341", mismatch, n);
        end
        p[0] = ~p[0];
        load(p);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if (mismatch !== 1'b0) begin
            miscompares++;
            $display("FAIL cmp_hold: mismatch=%b during frame, want 0", mismatch);
        end
        n = 0;
        run_to_valid(n);
        vectors++;
        if (mismatch !== 1'b1) begin
            miscompares++;
            $display("FAIL cmp_mismatch: got %b want 1", mismatch);
        end
    endtask
`endif

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        sr_dout = 1'b0;
        load('0);
`ifdef SR_READBACK_CMP_EN
        expected = '0;
`endif
        test_reset();
        test_single_frame();
        test_busy_ignore();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef SR_READBACK_CMP_EN
        test_compare();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
